// File: rtl/emu_step_scheduler.sv
// -----------------------------------------------------------------------------
// emu_step_scheduler
//
// Central timestep controller for a variable-timestep emulator. Each cycle it
// picks the smallest maximum-step request among the valid requesters and the
// global cap dt_max. It clamps that step so emulated time never passes tstop.
// It also gates the emulator clock enable and accumulates emulated time. Host
// run/stop/single-step commands drive a small FSM. A decimation counter
// produces a probe-capture strobe every (dec_thr+1) enabled cycles.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   dt_req         packed requests, requester i at [i*DT_WIDTH +: DT_WIDTH]
//   dt_req_valid   per-requester participation mask
//   dt_max         global step cap (always participates, loses all ties)
//   cmd_run        pulse: free-run
//   cmd_stop       pulse: stop / acknowledge halt (highest priority)
//   cmd_step       pulse: run step_count steps
//   step_count     number of steps for cmd_step (0 = command ignored)
//   tstop          stop time
//   tstop_en       enables the stop-time limit
//   dec_thr        decimation threshold
//   emu_cke        emulator clock enable (RUN or STEP)
//   emu_dt         granted step for the current cycle
//   emu_time       emulated time before the current step
//   grant_idx      winning requester; N_REQ means dt_max won
//   dec_strobe     decimated capture strobe
//   state          IDLE=0, RUN=1, STEP=2, HALT=3
//   halted         state == HALT
// -----------------------------------------------------------------------------
module emu_step_scheduler #(
  parameter int N_REQ      = 4,
  parameter int DT_WIDTH   = 16,
  parameter int TIME_WIDTH = 40,
  parameter int STEP_BITS  = 16,
  parameter int DEC_BITS   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ*DT_WIDTH-1:0]        dt_req,
  input  logic [N_REQ-1:0]                 dt_req_valid,
  input  logic [DT_WIDTH-1:0]              dt_max,
  input  logic                             cmd_run,
  input  logic                             cmd_stop,
  input  logic                             cmd_step,
  input  logic [STEP_BITS-1:0]             step_count,
  input  logic [TIME_WIDTH-1:0]            tstop,
  input  logic                             tstop_en,
  input  logic [DEC_BITS-1:0]              dec_thr,
  output logic                             emu_cke,
  output logic [DT_WIDTH-1:0]              emu_dt,
  output logic [TIME_WIDTH-1:0]            emu_time,
  output logic [$clog2(N_REQ+1)-1:0]       grant_idx,
  output logic                             dec_strobe,
  output logic [1:0]                       state,
  output logic                             halted
);

  localparam int IDX_W = $clog2(N_REQ + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t                 state_q;
  logic [TIME_WIDTH-1:0]  time_q;
  logic [STEP_BITS-1:0]   step_cnt;
  logic [DEC_BITS-1:0]    dec_cnt;

  logic [DT_WIDTH-1:0]    dt_sel;
  logic [IDX_W-1:0]       sel_idx;
  logic [TIME_WIDTH:0]    time_end;
  logic                   limit_hit;

  // Minimum search. Scanning from the highest index down with "<=" lets a
  // lower index replace an equal higher one, and lets any request beat an
  // equal dt_max, which is the seed value.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default before any branch, so the loop reads the updated running minimum
  // and no latch can be inferred.
  always_comb begin
    dt_sel  = dt_max;
    sel_idx = IDX_W'(N_REQ);
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (dt_req_valid[i] && (dt_req[i*DT_WIDTH +: DT_WIDTH] <= dt_sel)) begin
        dt_sel  = dt_req[i*DT_WIDTH +: DT_WIDTH];
        sel_idx = IDX_W'(i);
      end
    end
  end

  // One extra bit so the end-of-step time is compared without wrap-around.
  assign time_end  = {1'b0, time_q} + (TIME_WIDTH+1)'(dt_sel);
  assign limit_hit = tstop_en && (time_end >= {1'b0, tstop});

  // When clamped, the remaining distance is no larger than dt_sel, so it
  // always fits in DT_WIDTH.
  always_comb begin
    emu_dt = dt_sel;
    if (limit_hit) begin
      emu_dt = (time_q >= tstop) ? '0 : DT_WIDTH'(tstop - time_q);
    end
  end

  assign emu_cke    = (state_q == S_RUN) || (state_q == S_STEP);
  assign dec_strobe = emu_cke && (dec_cnt == dec_thr);
  assign emu_time   = time_q;
  assign grant_idx  = sel_idx;
  assign state      = state_q;
  assign halted     = (state_q == S_HALT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      time_q   <= '0;
      step_cnt <= '0;
      dec_cnt  <= '0;
    end else begin
      if (emu_cke) begin
        time_q  <= time_q + TIME_WIDTH'(emu_dt);
        dec_cnt <= dec_strobe ? '0 : dec_cnt + DEC_BITS'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_stop) begin
            state_q <= S_IDLE;
          end else if (cmd_step) begin
            // A zero-length step request is dropped, and it still outranks cmd_run.
            if (step_count != '0) begin
              state_q  <= S_STEP;
              step_cnt <= step_count;
            end
          end else if (cmd_run) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (cmd_stop) begin
            state_q <= S_IDLE;
          end else if (limit_hit) begin
            state_q <= S_HALT;
          end
        end
        S_STEP: begin
          if (cmd_stop) begin
            state_q  <= S_IDLE;
            step_cnt <= '0;
          end else begin
            step_cnt <= step_cnt - STEP_BITS'(1);
            // Reaching the stop time takes precedence over finishing the count.
            if (limit_hit) begin
              state_q <= S_HALT;
            end else if (step_cnt == STEP_BITS'(1)) begin
              state_q <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          if (cmd_stop) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emu_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_emu_step_scheduler
//
// Directed scenarios followed by a randomized phase. A transaction-level model
// tracks mode, emulated time, remaining steps and the decimation phase with
// plain integer arithmetic. Every cycle the DUT outputs are compared with the
// model on the falling edge, and the model advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_emu_step_scheduler;

  localparam int N_REQ      = 4;
  localparam int DT_WIDTH   = 16;
  localparam int TIME_WIDTH = 40;
  localparam int STEP_BITS  = 16;
  localparam int DEC_BITS   = 8;
  localparam longint unsigned TIME_MASK = (64'd1 << TIME_WIDTH) - 64'd1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ*DT_WIDTH-1:0]   dt_req;
  logic [N_REQ-1:0]            dt_req_valid;
  logic [DT_WIDTH-1:0]         dt_max;
  logic                        cmd_run;
  logic                        cmd_stop;
  logic                        cmd_step;
  logic [STEP_BITS-1:0]        step_count;
  logic [TIME_WIDTH-1:0]       tstop;
  logic                        tstop_en;
  logic [DEC_BITS-1:0]         dec_thr;
  logic                        emu_cke;
  logic [DT_WIDTH-1:0]         emu_dt;
  logic [TIME_WIDTH-1:0]       emu_time;
  logic [2:0]                  grant_idx;
  logic                        dec_strobe;
  logic [1:0]                  state;
  logic                        halted;

  emu_step_scheduler #(
    .N_REQ(N_REQ), .DT_WIDTH(DT_WIDTH), .TIME_WIDTH(TIME_WIDTH),
    .STEP_BITS(STEP_BITS), .DEC_BITS(DEC_BITS)
  ) dut (
    .clk(clk), .rst(rst), .dt_req(dt_req), .dt_req_valid(dt_req_valid),
    .dt_max(dt_max), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
    .cmd_step(cmd_step), .step_count(step_count), .tstop(tstop),
    .tstop_en(tstop_en), .dec_thr(dec_thr), .emu_cke(emu_cke),
    .emu_dt(emu_dt), .emu_time(emu_time), .grant_idx(grant_idx),
    .dec_strobe(dec_strobe), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3} mode_t;
  mode_t           m_mode;
  longint unsigned m_time;
  int              m_left;
  int              m_dec;

  // Observation log filled on every falling edge.
  int                  kcount = 0;
  int                  strobe_q[$];
  logic [DT_WIDTH-1:0] dt_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int v);
    dt_req[i*DT_WIDTH +: DT_WIDTH] = DT_WIDTH'(v);
  endtask

  // Winner = lexicographic minimum of (value, index) over the candidates, with
  // dt_max carrying index N_REQ. The step is then clamped to the stop time.
  function automatic void model_pick(output longint unsigned dt, output int idx,
                                     output bit limit);
    longint unsigned best_v;
    int              best_i;
    longint unsigned v;
    best_v = dt_max;
    best_i = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (dt_req_valid[i]) begin
        v = dt_req[i*DT_WIDTH +: DT_WIDTH];
        if ((v < best_v) || ((v == best_v) && (i < best_i))) begin
          best_v = v;
          best_i = i;
        end
      end
    end
    idx   = best_i;
    limit = tstop_en && ((m_time + best_v) >= longint'(tstop));
    if (limit) dt = (m_time >= longint'(tstop)) ? 0 : longint'(tstop) - m_time;
    else       dt = best_v;
  endfunction

  function automatic bit model_cke();
    return (m_mode == M_RUN) || (m_mode == M_STEP);
  endfunction

  task automatic check_outputs();
    longint unsigned dt;
    int              idx;
    bit              limit;
    bit              cke;
    model_pick(dt, idx, limit);
    cke = model_cke();
    check("emu_cke",    emu_cke,    cke);
    check("emu_time",   emu_time,   m_time);
    check("state",      state,      m_mode);
    check("halted",     halted,     m_mode == M_HALT);
    check("dec_strobe", dec_strobe, cke && (m_dec == int'(dec_thr)));
    if (cke) begin
      check("emu_dt",    emu_dt,    dt);
      check("grant_idx", grant_idx, idx);
    end
  endtask

  task automatic model_edge();
    longint unsigned dt;
    int              idx;
    bit              limit;
    if (rst) begin
      m_mode = M_IDLE;
      m_time = 0;
      m_left = 0;
      m_dec  = 0;
    end else begin
      model_pick(dt, idx, limit);
      if (model_cke()) begin
        m_time = (m_time + dt) & TIME_MASK;
        m_dec  = (m_dec == int'(dec_thr)) ? 0 : (m_dec + 1) % (1 << DEC_BITS);
      end
      case (m_mode)
        M_IDLE: begin
          if (cmd_stop) m_mode = M_IDLE;
          else if (cmd_step) begin
            if (step_count != 0) begin
              m_mode = M_STEP;
              m_left = int'(step_count);
            end
          end else if (cmd_run) m_mode = M_RUN;
        end
        M_RUN: begin
          if (cmd_stop)   m_mode = M_IDLE;
          else if (limit) m_mode = M_HALT;
        end
        M_STEP: begin
          if (cmd_stop) begin
            m_mode = M_IDLE;
            m_left = 0;
          end else begin
            m_left = m_left - 1;
            if (limit)            m_mode = M_HALT;
            else if (m_left == 0) m_mode = M_IDLE;
          end
        end
        default: if (cmd_stop) m_mode = M_IDLE;
      endcase
    end
  endtask

  // One clock: check on the falling edge, advance the model on the rising
  // edge, and return 1 time unit later so new inputs settle mid-cycle.
  task automatic cycle(input bit chk);
    @(negedge clk);
    if (chk) check_outputs();
    if (emu_cke === 1'b1) begin
      kcount++;
      dt_log.push_back(emu_dt);
      if (dec_strobe === 1'b1) strobe_q.push_back(kcount);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k0;
    logic [DT_WIDTH-1:0] exp_lim [5];
    exp_lim = '{16'd20, 16'd20, 16'd20, 16'd20, 16'd15};

    rst = 1'b1; dt_req = '0; dt_req_valid = '0; dt_max = 16'd100;
    cmd_run = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0; step_count = '0;
    tstop = '0; tstop_en = 1'b0; dec_thr = 8'd255;
    m_mode = M_IDLE; m_time = 0; m_left = 0; m_dec = 0;

    // Reset state.
    cycle(0);
    cycle(1);
    rst = 1'b0;
    check("rst_state",  state,      2'd0);
    check("rst_cke",    emu_cke,    1'b0);
    check("rst_time",   emu_time,   40'd0);
    check("rst_halted", halted,     1'b0);
    check("rst_strobe", dec_strobe, 1'b0);

    // Minimum selection with ties and fall-back to dt_max.
    set_req(0, 40); set_req(1, 25); set_req(2, 25); set_req(3, 60);
    dt_req_valid = 4'hF; dt_max = 16'd100;
    cmd_run = 1'b1; cycle(1); cmd_run = 1'b0;
    check("min_dt",   emu_dt,    16'd25);
    check("min_idx",  grant_idx, 3'd1);
    cycle(1);
    dt_req_valid = 4'b1101; #1;
    check("min_idx_drop1", grant_idx, 3'd2);
    check("min_dt_drop1",  emu_dt,    16'd25);
    cycle(1);
    dt_req_valid = 4'b0000; #1;
    check("min_dt_none",  emu_dt,    16'd100);
    check("min_idx_none", grant_idx, 3'd4);
    cycle(1);

    // Stop while running: exactly one further enabled cycle.
    k0 = kcount;
    cmd_stop = 1'b1; #1;
    check("stop_cke_same_cycle", emu_cke, 1'b1);
    cycle(1); cmd_stop = 1'b0;
    check("stop_state", state,   2'd0);
    check("stop_cke",   emu_cke, 1'b0);
    repeat (3) cycle(1);
    check("stop_one_more_cke", kcount - k0, 1);

    // All three commands together in IDLE: stop wins, nothing starts.
    cmd_stop = 1'b1; cmd_step = 1'b1; cmd_run = 1'b1; step_count = 16'd5;
    cycle(1);
    cmd_stop = 1'b0; cmd_step = 1'b0; cmd_run = 1'b0;
    check("prio_state", state,   2'd0);
    check("prio_cke",   emu_cke, 1'b0);
    cycle(1);

    // Single step of 3 at dt=10 from time 0.
    reset_pulse();
    dt_req_valid = '0; dt_max = 16'd10; step_count = 16'd3;
    k0 = kcount;
    cmd_step = 1'b1; cycle(1); cmd_step = 1'b0;
    repeat (6) cycle(1);
    check("step_cke_count", kcount - k0, 3);
    check("step_time",      emu_time,    40'd30);
    check("step_state",     state,       2'd0);
    check("step_cke_off",   emu_cke,     1'b0);

    // Stop-time limit: 20,20,20,20,15 then HALT.
    reset_pulse();
    tstop_en = 1'b1; tstop = 40'd95; dt_max = 16'd20;
    cmd_run = 1'b1; cycle(1); cmd_run = 1'b0;
    dt_log.delete();
    repeat (8) cycle(1);
    check("lim_nsteps", dt_log.size(), 5);
    for (int i = 0; i < dt_log.size() && i < 5; i++) check("lim_step_dt", dt_log[i], exp_lim[i]);
    check("lim_time",   emu_time, 40'd95);
    check("lim_state",  state,    2'd3);
    check("lim_halted", halted,   1'b1);
    cmd_run = 1'b1; cycle(1); cmd_run = 1'b0;
    check("halt_ignores_run", state, 2'd3);
    cmd_step = 1'b1; step_count = 16'd4; cycle(1); cmd_step = 1'b0;
    check("halt_ignores_step", state, 2'd3);
    cmd_stop = 1'b1; cycle(1); cmd_stop = 1'b0;
    check("halt_stop_idle", state, 2'd0);
    tstop_en = 1'b0;

    // Decimation: thr=3 gives strobes on enabled cycles 4 and 8; counter holds
    // across an idle gap, so the next strobe lands on enabled cycle 12.
    reset_pulse();
    dec_thr = 8'd3; dt_max = 16'd1;
    cmd_run = 1'b1; cycle(1); cmd_run = 1'b0;
    k0 = kcount;
    strobe_q.delete();
    repeat (9) cycle(1);
    cmd_stop = 1'b1; cycle(1); cmd_stop = 1'b0;
    check("dec_count", strobe_q.size(), 2);
    if (strobe_q.size() >= 2) begin
      check("dec_first",  strobe_q[0] - k0, 4);
      check("dec_second", strobe_q[1] - k0, 8);
    end
    repeat (5) cycle(1);
    cmd_run = 1'b1; cycle(1); cmd_run = 1'b0;
    repeat (3) cycle(1);
    check("dec_hold_count", strobe_q.size(), 3);
    if (strobe_q.size() >= 3) check("dec_hold_third", strobe_q[2] - k0, 12);
    cmd_stop = 1'b1; cycle(1); cmd_stop = 1'b0;

    // Reset in the middle of a 100-step sequence.
    reset_pulse();
    dec_thr = 8'd200; dt_max = 16'd5; step_count = 16'd100;
    cmd_step = 1'b1; cycle(1); cmd_step = 1'b0;
    repeat (10) cycle(1);
    check("mid_step_state", state, 2'd2);
    rst = 1'b1; cycle(1); rst = 1'b0;
    check("rst_mid_state", state,       2'd0);
    check("rst_mid_time",  emu_time,    40'd0);
    check("rst_mid_cke",   emu_cke,     1'b0);
    check("rst_mid_dec",   dut.dec_cnt, 8'd0);
    repeat (3) cycle(1);

    // Randomized phase, every cycle checked against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N_REQ; i++) set_req(i, int'($urandom_range(0, 40)));
      dt_req_valid = 4'($urandom);
      dt_max       = 16'($urandom_range(0, 50));
      cmd_run      = ($urandom_range(0, 9) == 0);
      cmd_step     = ($urandom_range(0, 11) == 0);
      cmd_stop     = ($urandom_range(0, 19) == 0);
      step_count   = 16'($urandom_range(1, 8));
      if ($urandom_range(0, 31) == 0) begin
        tstop_en = ~tstop_en;
        tstop    = TIME_WIDTH'(m_time + 64'($urandom_range(0, 300)));
      end
      if ($urandom_range(0, 63) == 0) dec_thr = 8'($urandom_range(0, 6));
      rst = ($urandom_range(0, 199) == 0);
      cycle(1);
    end
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0; rst = 1'b0;
    cycle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/emu_step_scheduler.md
Name: emu_step_scheduler

Overview:
- Central timestep controller for a variable-timestep emulator.
- Collects maximum-step requests from N analog/digital models and grants the smallest as the global emu_dt.
- Gates the emulator clock enable and accumulates emulated time.
- Implements host run/stop/single-step control, a stop-time limit and a decimation strobe for probe capture.

Parameters:
- N_REQ, 4, number of dt requesters
- DT_WIDTH, 16, width of dt values (unsigned, units of 1 time LSB)
- TIME_WIDTH, 40, width of emulated-time accumulator (unsigned, same LSB)
- STEP_BITS, 16, width of single-step count
- DEC_BITS, 8, width of decimation counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- dt_req  in  N_REQ*DT_WIDTH  packed requests; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH]
- dt_req_valid  in  N_REQ  requester i participates when 1
- dt_max  in  DT_WIDTH  global step cap; always participates
- cmd_run  in  1  pulse: free-run
- cmd_stop  in  1  pulse: stop / acknowledge halt
- cmd_step  in  1  pulse: run step_count steps
- step_count  in  STEP_BITS  steps for cmd_step
- tstop  in  TIME_WIDTH  stop time
- tstop_en  in  1  enables stop-time limit
- dec_thr  in  DEC_BITS  decimation threshold
- emu_cke  out  1  emulator clock enable
- emu_dt  out  DT_WIDTH  granted step for current cycle
- emu_time  out  TIME_WIDTH  emulated time before current step
- grant_idx  out  clog2(N_REQ+1)  winner index; N_REQ means dt_max won
- dec_strobe  out  1  decimated capture strobe
- state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
- halted  out  1  state==HALT

Behaviour:
- Reset values:
  - state=IDLE; emu_time=0; step counter=0; decimation counter=0.
  - emu_cke=0, dec_strobe=0, halted=0.
- Selection (combinational, same cycle):
  - dt_sel = min(dt_max, dt_req[i] for all valid i).
  - Ties: lowest index wins; dt_max loses all ties.
  - No valid requests: dt_sel=dt_max, grant_idx=N_REQ.
- Clamp:
  - If tstop_en and emu_time+dt_sel >= tstop, emu_dt = tstop-emu_time (0 if emu_time >= tstop) and limit_hit=1.
  - Otherwise emu_dt=dt_sel.
- emu_cke = state is RUN or STEP. Combinational from the state register only; commands affect emu_cke the cycle after they are sampled.
- On each clk edge with emu_cke=1:
  - emu_time <= emu_time+emu_dt.
  - Without tstop_en, wraps modulo 2^TIME_WIDTH.
  - emu_dt=0 is a legal step: cke still asserted, time unchanged.
- emu_dt and grant_idx are driven every cycle; they are only meaningful when emu_cke=1.
- FSM:
  - Command priority: cmd_stop > cmd_step > cmd_run.
  - IDLE:
    - cmd_step with step_count>0 -> STEP; load counter=step_count.
    - cmd_step with step_count=0 -> ignored.
    - cmd_run -> RUN.
  - RUN:
    - cmd_stop -> IDLE.
    - Else limit_hit -> HALT.
    - cmd_run and cmd_step are ignored.
  - STEP:
    - Counter decrements every cke cycle.
    - cmd_stop -> IDLE, counter cleared.
    - limit_hit -> HALT.
    - Counter==1 -> IDLE.
  - HALT:
    - cmd_stop -> IDLE (host must raise tstop or clear tstop_en before rerun).
    - All other commands are ignored.
- The step taken in the cycle cmd_stop is sampled still completes (cke already 1).
- When limit_hit and counter==1 coincide, HALT wins.
- Decimation:
  - Counter advances only on cke cycles.
  - dec_strobe = emu_cke && (dec_cnt==dec_thr).
  - On the strobe cycle the counter wraps to 0.
  - If dec_thr is lowered below the current count, the counter wraps at 2^DEC_BITS.
- rst mid-operation: all state returns to reset values on the next edge; any in-progress step count is discarded.

Test Plan:
- Min selection:
  - Setup: IDLE→RUN, dt_max=100, requests {40,25,25,60} all valid.
  - Required: emu_dt=25, grant_idx=1.
  - Then drop valid[1]: grant_idx=2.
  - Then drop all valid: emu_dt=100, grant_idx=4.
- Single step:
  - Stimulus: cmd_step with step_count=3, dt_sel=10, from emu_time=0.
  - Required: exactly 3 cke cycles, emu_time=30, then state=IDLE with cke=0.
- Stop limit:
  - Setup: tstop_en=1, tstop=95, dt_sel=20, RUN.
  - Required: steps 20,20,20,20,15; emu_time=95; HALT; halted=1; cmd_run ignored.
  - Then cmd_stop -> IDLE.
- Command priority:
  - Stimulus: cmd_stop+cmd_step+cmd_run in the same IDLE cycle -> state stays IDLE.
  - Stimulus: cmd_stop while in RUN.
  - Required: exactly one further cke cycle, then IDLE.
- Decimation:
  - Stimulus: dec_thr=3, RUN for 10 cycles.
  - Required: dec_strobe on cke cycles 4 and 8.
  - Required: with cke=0 the counter holds its value.
- Reset mid-STEP:
  - Stimulus: assert rst during a 100-step STEP sequence.
  - Required: next cycle state=IDLE, emu_time=0, cke=0, dec counter=0.
